// File: rtl/adc128s102_master_if.sv
// rtl/adc128s102_master_if.sv - host handshake and ADC pin bundle for adc128s102_master
// Ports (master view):
//   start, ch_mask                          in   scan request and channel enables
//   busy, data_vld, data_ch, data, done     out  scan status and results
//   SCLK, CSn, DIN                          out  ADC serial clock, chip select, control bits
//   DOUT                                    in   ADC serial data
`timescale 1ns/1ps
interface adc128s102_master_if;
  logic        start;
  logic [7:0]  ch_mask;
  logic        busy;
  logic        data_vld;
  logic [2:0]  data_ch;
  logic [11:0] data;
  logic        done;
  logic        SCLK;
  logic        CSn;
  logic        DIN;
  logic        DOUT;

  modport master (
    input  start, ch_mask, DOUT,
    output busy, data_vld, data_ch, data, done, SCLK, CSn, DIN
  );

  modport slave (
    output start, ch_mask, DOUT,
    input  busy, data_vld, data_ch, data, done, SCLK, CSn, DIN
  );
endinterface

// File: rtl/adc128s102_master.sv
// rtl/adc128s102_master.sv - SPI scan master for the ADC128S102 8-channel 12-bit ADC
// Ports:
//   CLK   in   system clock, rising edge
//   RSTn  in   asynchronous active-low reset
//   bus   adc128s102_master_if.master: start/ch_mask in, busy/data_vld/data_ch/data/done out,
//         SCLK/CSn/DIN out to the ADC, DOUT in from the ADC
`timescale 1ns/1ps
module adc128s102_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_IDLE = 4
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  adc128s102_master_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_HOLD
  } state_t;

  localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [15:0] IDLE_LOAD = 16'(CS_IDLE);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;         // CLK count within the current SCLK half-period
  logic [3:0]  bit_q, bit_d;         // frame bit index, 15 down to 0
  logic [7:0]  rem_q, rem_d;         // channels still to be addressed in this burst
  logic [2:0]  prev_ch_q, prev_ch_d; // channel addressed in the previous frame
  logic        first_q, first_d;     // frame 0: its result belongs to no requested channel
  logic [11:0] rx_q, rx_d;           // only the last 12 DOUT bits of a frame are kept
  logic [15:0] idle_q, idle_d;       // CSn-high guard time after a burst
  logic        sclk_q, sclk_d;
  logic        csn_q, csn_d;
  logic        din_q, din_d;
  logic        busy_q, busy_d;
  logic        vld_q, vld_d;
  logic        done_q, done_d;
  logic [11:0] data_q, data_d;
  logic [2:0]  data_ch_q, data_ch_d;

  logic [2:0]  cur_ch;
  logic        rem_any;
  logic        div_end;

  // Control word: bits 13:11 carry the address, everything else is zero.
  function automatic logic ctrl_bit(input logic [3:0] b, input logic [2:0] addr);
    case (b)
      4'd13:   ctrl_bit = addr[2];
      4'd12:   ctrl_bit = addr[1];
      4'd11:   ctrl_bit = addr[0];
      default: ctrl_bit = 1'b0;
    endcase
  endfunction

  // Lowest pending channel is the one addressed in the current frame; once the
  // mask is exhausted the trailing frame addresses channel 0.
  always_comb begin
    cur_ch = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rem_q[i]) cur_ch = 3'(i);
    end
  end

  assign rem_any = |rem_q;
  assign div_end = (div_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    rem_d     = rem_q;
    prev_ch_d = prev_ch_q;
    first_d   = first_q;
    rx_d      = rx_q;
    idle_d    = idle_q;
    sclk_d    = sclk_q;
    csn_d     = csn_q;
    din_d     = din_q;
    busy_d    = busy_q;
    vld_d     = 1'b0;
    done_d    = 1'b0;
    data_d    = data_q;
    data_ch_d = data_ch_q;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (idle_q != 16'd0) idle_d = idle_q - 16'd1;
        // busy_q is still set in the cycle after an empty-mask scan, so a
        // start arriving then is dropped like any other start while busy.
        if (bus.start && !busy_q && idle_q == 16'd0) begin
          busy_d = 1'b1;
          if (bus.ch_mask == 8'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_SETUP;
            csn_d   = 1'b0;
            rem_d   = bus.ch_mask;
            first_d = 1'b1;
            bit_d   = 4'd15;
            div_d   = 8'd0;
          end
        end
      end

      ST_SETUP: begin
        if (div_end) begin
          state_d = ST_LOW;
          sclk_d  = 1'b0;
          din_d   = ctrl_bit(bit_q, cur_ch);
          div_d   = 8'd0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      ST_LOW: begin
        if (div_end) begin
          state_d = ST_HIGH;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[10:0], bus.DOUT};
          div_d   = 8'd0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      ST_HIGH: begin
        // First cycle after the rising edge that captured bit 0.
        if (div_q == 8'd0 && bit_q == 4'd0 && !first_q) begin
          vld_d     = 1'b1;
          data_d    = rx_q;
          data_ch_d = prev_ch_q;
        end
        if (div_end) begin
          div_d = 8'd0;
          if (bit_q != 4'd0) begin
            state_d = ST_LOW;
            sclk_d  = 1'b0;
            bit_d   = bit_q - 4'd1;
            din_d   = ctrl_bit(bit_q - 4'd1, cur_ch);
          end else if (rem_any) begin
            // Next frame starts straight away; its address bits come from
            // the mask with the just-sent channel removed.
            state_d   = ST_LOW;
            sclk_d    = 1'b0;
            bit_d     = 4'd15;
            din_d     = 1'b0;
            rem_d     = rem_q & ~(8'd1 << cur_ch);
            prev_ch_d = cur_ch;
            first_d   = 1'b0;
          end else begin
            state_d = ST_HOLD;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      ST_HOLD: begin
        if (div_end) begin
          state_d = ST_IDLE;
          csn_d   = 1'b1;
          din_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          idle_d  = IDLE_LOAD;
          div_d   = 8'd0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= ST_IDLE;
      div_q     <= 8'd0;
      bit_q     <= 4'd0;
      rem_q     <= 8'd0;
      prev_ch_q <= 3'd0;
      first_q   <= 1'b0;
      rx_q      <= 12'd0;
      idle_q    <= 16'd0;
      sclk_q    <= 1'b1;
      csn_q     <= 1'b1;
      din_q     <= 1'b0;
      busy_q    <= 1'b0;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= 12'd0;
      data_ch_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      rem_q     <= rem_d;
      prev_ch_q <= prev_ch_d;
      first_q   <= first_d;
      rx_q      <= rx_d;
      idle_q    <= idle_d;
      sclk_q    <= sclk_d;
      csn_q     <= csn_d;
      din_q     <= din_d;
      busy_q    <= busy_d;
      vld_q     <= vld_d;
      done_q    <= done_d;
      data_q    <= data_d;
      data_ch_q <= data_ch_d;
    end
  end

  assign bus.SCLK     = sclk_q;
  assign bus.CSn      = csn_q;
  assign bus.DIN      = din_q;
  assign bus.busy     = busy_q;
  assign bus.data_vld = vld_q;
  assign bus.done     = done_q;
  assign bus.data     = data_q;
  assign bus.data_ch  = data_ch_q;

endmodule

// File: tb/tb_adc128s102_master.sv
// tb/tb_adc128s102_master.sv - randomized self-checking bench for adc128s102_master
`timescale 1ns/1ps
module tb_adc128s102_master;
  localparam int CLK_DIV = 4;
  localparam int CS_IDLE = 4;
  localparam int T       = 10;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;

  adc128s102_master_if bus ();

  adc128s102_master #(.CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  always #(T/2) CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ADC behaviour: samples DIN on SCLK rise, shifts out the conversion of the
  // address received in the previous frame, MSB first after each SCLK fall.
  logic [11:0] adc_val [8];
  logic [15:0] tx_word = 16'h0;
  logic [15:0] ctl_sr  = 16'h0;
  logic        m_csn   = 1'b1;
  logic        m_sclk  = 1'b1;
  int          rise_in_frame = 0;
  int          sclk_rises = 0;
  int          csn_falls  = 0;
  int          setup_viol = 0;
  int          hold_viol  = 0;
  time         t_din = 0, t_rise = 0, t_csn_fall = 0, csn_low_len = 0;
  logic [2:0]  addr_seen [$];
  logic [14:0] obs_q [$];

  always @(bus.CSn or bus.SCLK) begin
    if (bus.CSn !== m_csn) begin
      m_csn = bus.CSn;
      if (bus.CSn === 1'b0) begin
        csn_falls++;
        t_csn_fall    = $time;
        rise_in_frame = 0;
        tx_word       = {4'h0, adc_val[0]};
      end else begin
        csn_low_len = $time - t_csn_fall;
      end
    end
    if (bus.SCLK !== m_sclk) begin
      m_sclk = bus.SCLK;
      if (bus.CSn === 1'b0) begin
        if (bus.SCLK === 1'b0) begin
          bus.DOUT = tx_word[15 - rise_in_frame];
        end else begin
          sclk_rises++;
          if ($time - t_din < CLK_DIV * T) setup_viol++;
          t_rise = $time;
          ctl_sr = {ctl_sr[14:0], bus.DIN};
          rise_in_frame++;
          if (rise_in_frame == 16) begin
            rise_in_frame = 0;
            addr_seen.push_back(ctl_sr[13:11]);
            tx_word = {4'h0, adc_val[ctl_sr[13:11]]};
          end
        end
      end
    end
  end

  always @(bus.DIN) begin
    if (bus.CSn === 1'b0 && ($time - t_rise) < CLK_DIV * T) hold_viol++;
    t_din = $time;
  end

  always @(negedge CLK) begin
    if (bus.data_vld === 1'b1) obs_q.push_back({bus.data_ch, bus.data});
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic run_scan(input logic [7:0] mask, input bit poke_mid);
    int          n, base_obs, base_falls, base_rises, base_addr, base_sv, base_hv;
    logic        prev_csn;
    bit          seen;
    logic [14:0] exp_res [$];
    logic [2:0]  exp_addr [$];
    n = $countones(mask);
    for (int c = 0; c < 8; c++) begin
      if (mask[c]) begin
        exp_res.push_back({3'(c), adc_val[c]});
        exp_addr.push_back(3'(c));
      end
    end
    exp_addr.push_back(3'd0);
    base_obs   = obs_q.size();
    base_falls = csn_falls;
    base_rises = sclk_rises;
    base_addr  = addr_seen.size();
    base_sv    = setup_viol;
    base_hv    = hold_viol;

    @(negedge CLK);
    bus.start   = 1'b1;
    bus.ch_mask = mask;
    @(negedge CLK);
    bus.start   = 1'b0;
    bus.ch_mask = 8'($urandom);
    chk("busy_on_accept", bus.busy, 1);

    prev_csn = 1'b1;
    seen     = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (poke_mid && c == 200) bus.start = 1'b1;
      if (poke_mid && c == 201) begin
        bus.start = 1'b0;
        chk("busy_mid_burst", bus.busy, 1);
      end
      prev_csn = bus.CSn;
      @(negedge CLK);
    end
    chk("done_seen", seen, 1);
    chk("csn_high_at_done", bus.CSn, 1);
    chk("csn_before_done", prev_csn, (mask == 8'd0) ? 1 : 0);
    chk("busy_at_done", bus.busy, (mask == 8'd0) ? 1 : 0);
    @(negedge CLK);
    chk("done_one_cycle", bus.done, 0);
    chk("busy_cleared", bus.busy, 0);
    chk("csn_falls", csn_falls - base_falls, (mask == 8'd0) ? 0 : 1);
    chk("vld_count", obs_q.size() - base_obs, n);
    for (int i = 0; i < n && base_obs + i < obs_q.size(); i++) begin
      chk("data_ch", 32'(obs_q[base_obs + i][14:12]), 32'(exp_res[i][14:12]));
      chk("data", 32'(obs_q[base_obs + i][11:0]), 32'(exp_res[i][11:0]));
    end
    if (mask != 8'd0) begin
      chk("sclk_rises", sclk_rises - base_rises, (n + 1) * 16);
      chk("csn_low_clks", 32'(csn_low_len / T), (n + 1) * 32 * CLK_DIV + 2 * CLK_DIV);
      chk("frames", addr_seen.size() - base_addr, n + 1);
      for (int i = 0; i <= n && base_addr + i < addr_seen.size(); i++)
        chk("din_addr", 32'(addr_seen[base_addr + i]), 32'(exp_addr[i]));
      chk("din_setup", setup_viol - base_sv, 0);
      chk("din_hold", hold_viol - base_hv, 0);
    end
  endtask

  task automatic rand_vals();
    for (int c = 0; c < 8; c++) adc_val[c] = 12'($urandom);
  endtask

  initial begin
    int   base_obs;
    logic [7:0] m;
    bit   ok;
    bus.start   = 1'b0;
    bus.ch_mask = 8'd0;
    rand_vals();

    repeat (3) @(negedge CLK);
    chk("rst_sclk", bus.SCLK, 1);
    chk("rst_csn", bus.CSn, 1);
    chk("rst_din", bus.DIN, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_vld", bus.data_vld, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_data", bus.data, 0);
    chk("rst_data_ch", bus.data_ch, 0);
    RSTn = 1'b1;
    idle_cycles(2);

    rand_vals();
    adc_val[0] = 12'hABC;
    run_scan(8'h01, 1'b0);
    idle_cycles(8);

    for (int c = 0; c < 8; c++) adc_val[c] = 12'h100 + 12'(c);
    run_scan(8'hFF, 1'b0);
    idle_cycles(8);

    rand_vals();
    run_scan(8'hA4, 1'b0);
    idle_cycles(8);

    run_scan(8'h00, 1'b0);
    idle_cycles(8);

    // Start mid-burst, then one CLK after done; only the start 4 CLKs after done counts.
    rand_vals();
    run_scan(8'($urandom_range(1, 255)), 1'b1);
    bus.start   = 1'b1;
    bus.ch_mask = 8'h3C;
    @(negedge CLK);
    bus.start = 1'b0;
    chk("early_start_busy", bus.busy, 0);
    chk("early_start_csn", bus.CSn, 1);
    @(negedge CLK);
    chk("early_start_busy2", bus.busy, 0);
    run_scan(8'($urandom_range(1, 255)), 1'b0);
    idle_cycles(8);

    // Asynchronous reset during frame 2 of a full scan.
    rand_vals();
    @(negedge CLK);
    bus.start   = 1'b1;
    bus.ch_mask = 8'hFF;
    m = 8'(addr_seen.size());
    @(negedge CLK);
    bus.start = 1'b0;
    for (int c = 0; c < 5000 && addr_seen.size() < 32'(m) + 2; c++) @(negedge CLK);
    ok = (addr_seen.size() >= 32'(m) + 2);
    chk("reached_frame2", ok, 1);
    #2 RSTn = 1'b0;
    #1;
    chk("async_rst_sclk", bus.SCLK, 1);
    chk("async_rst_csn", bus.CSn, 1);
    chk("async_rst_busy", bus.busy, 0);
    base_obs = obs_q.size();
    repeat (5) @(negedge CLK);
    RSTn = 1'b1;
    repeat (300) @(negedge CLK);
    chk("no_vld_after_reset", obs_q.size() - base_obs, 0);
    rand_vals();
    run_scan(8'hFF, 1'b0);
    idle_cycles(8);

    repeat (4) begin
      rand_vals();
      run_scan(8'($urandom_range(1, 255)), 1'b0);
      idle_cycles(6 + $urandom_range(0, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
